sha256_msg_padder: RTL and testbench

Upstream feeder for `sha256_module`. It accepts an arbitrary-length message as a stream of 32-bit words and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It emits the result as one or more 512-bit blocks, issuing one block per `start` pulse and waiting for the core's `done` before it issues the next block.

---
 rtl/sha256_msg_padder.sv | 180 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - FIPS 180-4 message padder feeding 512-bit blocks to sha256_module.
// Define SHA256_PAD_BSWAP_EN to accept little-endian input words (byte-reversed before storage).
module sha256_msg_padder #(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_start,
    output logic         blk_first,
    output logic         blk_last,
    input  logic         core_done,
    output logic         busy
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_PAD, S_EXTRA, S_ISSUE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [511:0]       buf_q, buf_d;
    logic [3:0]         widx_q, widx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         lb_q, lb_d;
    logic               first_pend_q, first_pend_d;
    logic               first_out_q, first_out_d;
    logic               last_out_q, last_out_d;
    logic               extra_q, extra_d;
    logic               placed_q, placed_d;

    logic [31:0]        in_word;
    logic [2:0]         lb_in;
    logic [2:0]         word_add;
    logic [6:0]         pad_pos;
    logic [63:0]        bitlen;

`ifdef SHA256_PAD_BSWAP_EN
    assign in_word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
    assign in_word = in_data;
`endif

    assign lb_in    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign word_add = in_last ? lb_in : 3'd4;
    // Byte offset of the 0x80 marker inside the block; 64 means it spills into the next block.
    assign pad_pos  = 7'({widx_q, 2'b00}) + 7'(lb_q);
    assign bitlen   = 64'(cnt_q) << 3;

    assign in_ready  = reset_n && ((state_q == S_IDLE) || (state_q == S_FILL));
    assign blk_data  = buf_q;
    assign blk_start = (state_q == S_ISSUE);
    assign blk_first = first_out_q;
    assign blk_last  = last_out_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        widx_d       = widx_q;
        cnt_d        = cnt_q;
        lb_d         = lb_q;
        first_pend_d = first_pend_q;
        first_out_d  = first_out_q;
        last_out_d   = last_out_q;
        extra_d      = extra_q;
        placed_d     = placed_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    buf_d        = '0;
                    buf_d[31:0]  = in_word;
                    cnt_d        = CNT_W'(word_add);
                    lb_d         = lb_in;
                    first_pend_d = 1'b1;
                    extra_d      = 1'b0;
                    placed_d     = 1'b0;
                    widx_d       = in_last ? 4'd0 : 4'd1;
                    state_d      = in_last ? S_PAD : S_FILL;
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    buf_d[{widx_q, 5'd0} +: 32] = in_word;
                    cnt_d = cnt_q + CNT_W'(word_add);
                    lb_d  = lb_in;
                    if (in_last) begin
                        state_d = S_PAD;
                    end else if (widx_q == 4'd15) begin
                        first_out_d = first_pend_q;
                        last_out_d  = 1'b0;
                        state_d     = S_ISSUE;
                    end else begin
                        widx_d = widx_q + 4'd1;
                    end
                end
            end
            S_PAD: begin
                for (int b = 0; b < 64; b++) begin
                    if (7'(b) == pad_pos) begin
                        buf_d[32*(b/4) + 24 - 8*(b%4) +: 8] = 8'h80;
                    end else if (7'(b) > pad_pos) begin
                        buf_d[32*(b/4) + 24 - 8*(b%4) +: 8] = 8'h00;
                    end
                end
                first_out_d = first_pend_q;
                if (pad_pos < 7'd56) begin
                    buf_d[14*32 +: 32] = bitlen[63:32];
                    buf_d[15*32 +: 32] = bitlen[31:0];
                    last_out_d = 1'b1;
                end else begin
                    last_out_d = 1'b0;
                    extra_d    = 1'b1;
                    placed_d   = (pad_pos != 7'd64);
                end
                state_d = S_ISSUE;
            end
            S_EXTRA: begin
                buf_d = '0;
                if (!placed_q) begin
                    buf_d[31:0] = 32'h8000_0000;
                end
                buf_d[14*32 +: 32] = bitlen[63:32];
                buf_d[15*32 +: 32] = bitlen[31:0];
                extra_d     = 1'b0;
                first_out_d = first_pend_q;
                last_out_d  = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                first_pend_d = 1'b0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    first_out_d = 1'b0;
                    last_out_d  = 1'b0;
                    if (extra_q) begin
                        state_d = S_EXTRA;
                    end else if (last_out_q) begin
                        state_d = S_IDLE;
                    end else begin
                        widx_d  = 4'd0;
                        state_d = S_FILL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            widx_q       <= '0;
            cnt_q        <= '0;
            lb_q         <= '0;
            first_pend_q <= 1'b0;
            first_out_q  <= 1'b0;
            last_out_q   <= 1'b0;
            extra_q      <= 1'b0;
            placed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            widx_q       <= widx_d;
            cnt_q        <= cnt_d;
            lb_q         <= lb_d;
            first_pend_q <= first_pend_d;
            first_out_q  <= first_out_d;
            last_out_q   <= last_out_d;
            extra_q      <= extra_d;
            placed_q     <= placed_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - randomized bench for sha256_msg_padder against a byte-queue padding model.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_valid;
    logic         in_last;
    wire          in_ready;
    wire  [511:0] blk_data;
    wire          blk_start;
    wire          blk_first;
    wire          blk_last;
    wire          core_done;
    wire          busy;

    logic resp_done  = 1'b0;
    logic stray_done = 1'b0;
    assign core_done = resp_done | stray_done;

    always #5 clk = ~clk;

    sha256_msg_padder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_start (blk_start),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .core_done (core_done),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core stand-in: records each issued block, holds it for a while, then pulses done.
    logic [511:0] got_data[$];
    bit           got_first[$];
    bit           got_last[$];
    int           got_start[$];
    int           got_done[$];
    bit           resp_busy = 1'b0;
    bit           bp_mode   = 1'b0;
    logic [511:0] r_d;
    bit           r_f, r_l;
    int           r_dly;

    initial begin
        forever begin
            @(negedge clk);
            if (blk_start === 1'b1) begin
                resp_busy = 1'b1;
                r_d = blk_data;
                r_f = blk_first;
                r_l = blk_last;
                got_data.push_back(r_d);
                got_first.push_back(r_f);
                got_last.push_back(r_l);
                got_start.push_back(cyc);
                r_dly = bp_mode ? 100 : int'($urandom_range(0, 4));
                for (int i = 0; i < r_dly; i++) begin
                    @(negedge clk);
                    check("hold_data", blk_data, r_d);
                    check("hold_ready", in_ready, 1'b0);
                end
                @(negedge clk);
                resp_done = 1'b1;
                got_done.push_back(cyc);
                check("done_data", blk_data, r_d);
                check("done_first", blk_first, r_f);
                check("done_last", blk_last, r_l);
                @(negedge clk);
                resp_done = 1'b0;
                if (r_l) begin
                    check("ready_after_last", in_ready, 1'b1);
                    check("idle_after_last", busy, 1'b0);
                end
                resp_busy = 1'b0;
            end
        end
    end

    byte unsigned msg_q[$];
    byte unsigned pad_q[$];

    function automatic void build_pad();
        longint unsigned bits;
        pad_q = msg_q;
        pad_q.push_back(8'h80);
        while (pad_q.size() % 64 != 56) pad_q.push_back(8'h00);
        bits = longint'(msg_q.size()) * 8;
        for (int i = 7; i >= 0; i--) pad_q.push_back(byte'(bits >> (8 * i)));
    endfunction

    task automatic drive_word(input logic [31:0] d, input logic [2:0] b, input bit last, output bit ok);
        int budget;
        in_data  = d;
        in_bytes = b;
        in_last  = last;
        in_valid = 1'b1;
        ok       = 1'b0;
        budget   = 0;
        while (!ok && budget < 1000) begin
            if (in_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] make_word(input int k);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            if (4 * k + j < msg_q.size()) w[31 - 8*j -: 8] = msg_q[4*k + j];
            else                         w[31 - 8*j -: 8] = 8'($urandom_range(0, 255));
        end
        return w;
    endfunction

    task automatic send_msg(input bit use_stray);
        int n, nw, base, nblk, budget, rem;
        bit ok, last;
        logic [2:0] b;
        logic [511:0] exp;
        n    = msg_q.size();
        nw   = (n == 0) ? 1 : (n + 3) / 4;
        base = got_data.size();
        build_pad();
        nblk = pad_q.size() / 64;
        for (int k = 0; k < nw; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            last = (k == nw - 1);
            rem  = n - 4 * k;
            if (!last)         b = 3'($urandom_range(0, 7));
            else if (rem == 4) b = 3'($urandom_range(4, 7));
            else               b = 3'(rem);
            drive_word(make_word(k), b, last, ok);
            if (last) begin
                check("pad_gap", blk_start, 1'b0);
                @(negedge clk);
                check("final_lat", blk_start, 1'b1);
            end else if (k % 16 == 15) begin
                check("full_lat", blk_start, 1'b1);
            end
            if (use_stray && k == 2) begin
                stray_done = 1'b1;
                @(negedge clk);
                stray_done = 1'b0;
                check("stray_busy", busy, 1'b1);
                check("stray_ready", in_ready, 1'b1);
            end
        end
        budget = 0;
        while ((got_data.size() < base + nblk || resp_busy) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check("block_count", got_data.size() - base, nblk);
        if (got_data.size() == base + nblk) begin
            for (int bk = 0; bk < nblk; bk++) begin
                exp = '0;
                for (int i = 0; i < 16; i++)
                    exp[32*i +: 32] = {pad_q[64*bk + 4*i], pad_q[64*bk + 4*i + 1],
                                       pad_q[64*bk + 4*i + 2], pad_q[64*bk + 4*i + 3]};
                check($sformatf("blk_data n=%0d b=%0d", n, bk), got_data[base + bk], exp);
                check("blk_first", got_first[base + bk], bk == 0);
                check("blk_last", got_last[base + bk], bk == nblk - 1);
            end
            if (nblk > 1 && n <= 64 * (nblk - 1))
                check("extra_lat", got_start[base + nblk - 1] - got_done[base + nblk - 2], 2);
        end
    endtask

    task automatic rand_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic abc_test();
        logic [511:0] exp;
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
        send_msg(1'b0);
        exp = '0;
        exp[31:0]    = 32'h6162_6380;
        exp[511:480] = 32'h0000_0018;
        check("abc_block", got_data[got_data.size() - 1], exp);
    endtask

    int lens[9] = '{0, 56, 64, 55, 63, 119, 128, 1, 4};
    bit ok;

    initial begin
        reset_n  = 1'b0;
        in_data  = '0;
        in_bytes = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 1'b0);
        check("rst_data", blk_data, '0);
        check("rst_start", blk_start, 1'b0);
        check("rst_flags", {blk_first, blk_last, busy}, 3'b000);
        reset_n = 1'b1;
        #1;
        check("rel_ready", in_ready, 1'b1);
        @(negedge clk);

        abc_test();
        foreach (lens[i]) begin
            rand_msg(lens[i]);
            send_msg(1'b0);
        end

        bp_mode = 1'b1;
        rand_msg(20);
        send_msg(1'b0);
        bp_mode = 1'b0;

        rand_msg(30);
        send_msg(1'b1);

        for (int t = 0; t < 10; t++) begin
            rand_msg($urandom_range(0, 200));
            send_msg(1'b0);
        end

        rand_msg(40);
        for (int k = 0; k < 5; k++) drive_word(make_word(k), 3'd4, 1'b0, ok);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_data", blk_data, '0);
        check("mid_rst_flags", {blk_start, blk_first, blk_last, busy}, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rel_ready", in_ready, 1'b1);
        @(negedge clk);
        abc_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
